// File: rtl/psram_pkg.sv
// Command codes and FSM state encoding shared by the PSRAM device model.
package psram_pkg;

  localparam logic [7:0] CMD_READ   = 8'hEB;
  localparam logic [7:0] CMD_WRITE  = 8'h38;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    WAIT,
    RDATA,
    WDATA,
    MODE,
    ERR
  } psram_state_e;

endpackage

// File: rtl/psram_byte_ram.sv
// Byte-wide storage array: one registered read port, one write port.
// Contents are deliberately not reset.
module psram_byte_ram #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data
);

  logic [7:0] mem [2**AW];
  logic [7:0] rd_data_q;

  // Write port: commits on the clock edge that ends the request cycle.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: data appears one clock after rd_en and holds until the next read.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/psram_qpi_model.sv
// PSRAM device model: samples sck/ce_n/dio on the system clock, decodes
// SPI/QPI commands and serves quad reads and writes from an internal array.
// The address shifter keeps only the low MEM_AW bits, so MEM_AW must be >= 5.
module psram_qpi_model
  import psram_pkg::*;
#(
  parameter int MEM_AW     = 12,
  parameter int RD_WAIT    = 7,
  parameter int WRAP_BYTES = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] dio_i,
  output logic [3:0] dio_o,
  output logic [3:0] dio_oe,
  output logic       qpi_mode,
  output logic       err
);

  // Bits under the mask advance and wrap; bits above it stay fixed in a burst.
  localparam logic [MEM_AW-1:0] WRAP_MASK =
    (WRAP_BYTES == 0) ? {MEM_AW{1'b1}} : MEM_AW'(WRAP_BYTES - 1);
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

  psram_state_e      state_q, state_d;
  logic              sck_q, ce_n_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              lo_q, lo_d;         // next data nibble is the low half
  logic [3:0]        hi_nib_q, hi_nib_d; // high half of the byte being written
  logic              qpi_q, qpi_d;
  logic              err_q, err_d;
  logic [3:0]        dio_o_q, dio_o_d;
  logic [3:0]        dio_oe_q, dio_oe_d;

  logic              rise, fall, ce_rise;
  logic [7:0]        cmd_shift;
  logic [MEM_AW-1:0] addr_inc;
  logic              rd_en, wr_en;
  logic [MEM_AW-1:0] rd_addr;
  logic [7:0]        rd_data, wr_data;

  assign rise    = !sck_q && sck;
  assign fall    = sck_q && !sck;
  assign ce_rise = ce_n && !ce_n_q;

  assign cmd_shift = qpi_q ? {cmd_q[3:0], dio_i} : {cmd_q[6:0], dio_i[0]};
  assign addr_inc  = (addr_q & ~WRAP_MASK) | ((addr_q + 1'b1) & WRAP_MASK);
  assign wr_data   = {hi_nib_q, dio_i};

  psram_byte_ram #(.AW(MEM_AW)) u_ram (
    .clock   (clock),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en && !reset),
    .wr_addr (addr_q),
    .wr_data (wr_data)
  );

  // Next-state, shifters, address generator and array requests.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    lo_d     = lo_q;
    hi_nib_d = hi_nib_q;
    qpi_d    = qpi_q;
    err_d    = 1'b0;
    dio_o_d  = dio_o_q;
    dio_oe_d = dio_oe_q;
    rd_en    = 1'b0;
    rd_addr  = addr_q;
    wr_en    = 1'b0;

    if (ce_n) begin
      // MODE is only reachable after exactly 8 command bits, so the
      // deselect edge is where the mode switch takes effect.
      if (ce_rise && state_q == MODE) begin
        qpi_d = (cmd_q == CMD_QPI_EN);
      end
      state_d  = CMD;
      cnt_d    = 4'd0;
      lo_d     = 1'b0;
      dio_o_d  = 4'h0;
      dio_oe_d = 4'h0;
    end else begin
      case (state_q)
        CMD: begin
          if (rise) begin
            cmd_d = cmd_shift;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == (qpi_q ? 4'd1 : 4'd7)) begin
              cnt_d = 4'd0;
              case (cmd_shift)
                CMD_READ, CMD_WRITE:   state_d = ADDR;
                CMD_QPI_EN, CMD_QPI_EX: state_d = MODE;
                default: begin
                  state_d = ERR;
                  err_d   = 1'b1;
                end
              endcase
            end
          end
        end
        ADDR: begin
          if (rise) begin
            addr_d = {addr_q[MEM_AW-5:0], dio_i};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd5) begin
              cnt_d   = 4'd0;
              lo_d    = 1'b0;
              state_d = (cmd_q == CMD_READ) ? WAIT : WDATA;
            end
          end
        end
        WAIT: begin
          if (fall) begin
            dio_oe_d = 4'hF;
            dio_o_d  = 4'h0;
          end
          if (rise) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == WAIT_LAST) begin
              cnt_d   = 4'd0;
              rd_en   = 1'b1;
              state_d = RDATA;
            end
          end
        end
        RDATA: begin
          if (fall) begin
            dio_oe_d = 4'hF;
            if (!lo_q) begin
              dio_o_d = rd_data[7:4];
              lo_d    = 1'b1;
            end else begin
              // Prefetch the next byte; it lands long before the next fall.
              dio_o_d = rd_data[3:0];
              lo_d    = 1'b0;
              addr_d  = addr_inc;
              rd_en   = 1'b1;
              rd_addr = addr_inc;
            end
          end
        end
        WDATA: begin
          if (rise) begin
            if (!lo_q) begin
              hi_nib_d = dio_i;
              lo_d     = 1'b1;
            end else begin
              wr_en  = 1'b1;
              lo_d   = 1'b0;
              addr_d = addr_inc;
            end
          end
        end
        MODE, ERR: begin
        end
        default: state_d = CMD;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= CMD;
      sck_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      cnt_q    <= 4'd0;
      cmd_q    <= 8'h00;
      addr_q   <= '0;
      lo_q     <= 1'b0;
      hi_nib_q <= 4'h0;
      qpi_q    <= 1'b0;
      err_q    <= 1'b0;
      dio_o_q  <= 4'h0;
      dio_oe_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      sck_q    <= sck;
      ce_n_q   <= ce_n;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      lo_q     <= lo_d;
      hi_nib_q <= hi_nib_d;
      qpi_q    <= qpi_d;
      err_q    <= err_d;
      dio_o_q  <= dio_o_d;
      dio_oe_q <= dio_oe_d;
    end
  end

  assign dio_o    = dio_o_q;
  assign dio_oe   = dio_oe_q;
  assign qpi_mode = qpi_q;
  assign err      = err_q;

endmodule

// File: tb/tb_psram_qpi_model.sv
// Bench for psram_qpi_model: a linear instance (a) and a 4-byte wrap
// instance (b) share sck/dio_i, each has its own chip select.
module tb_psram_qpi_model;

  localparam int AW    = 12;
  localparam int RW    = 7;
  localparam int DEPTH = 1 << AW;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       sck    = 1'b0;
  logic       ce_n_a = 1'b1;
  logic       ce_n_b = 1'b1;
  logic [3:0] dio_i  = 4'h0;
  logic [3:0] dio_o_a, dio_oe_a, dio_o_b, dio_oe_b;
  logic       qpi_a, qpi_b, err_a, err_b;

  psram_qpi_model #(.MEM_AW(AW), .RD_WAIT(RW), .WRAP_BYTES(0)) dut_a (
    .clock(clock), .reset(reset), .sck(sck), .ce_n(ce_n_a), .dio_i(dio_i),
    .dio_o(dio_o_a), .dio_oe(dio_oe_a), .qpi_mode(qpi_a), .err(err_a)
  );

  psram_qpi_model #(.MEM_AW(AW), .RD_WAIT(RW), .WRAP_BYTES(4)) dut_b (
    .clock(clock), .reset(reset), .sck(sck), .ce_n(ce_n_b), .dio_i(dio_i),
    .dio_o(dio_o_b), .dio_oe(dio_oe_b), .qpi_mode(qpi_b), .err(err_b)
  );

  always #5 clock = ~clock;

  // Scoreboard state and reference model.
  int         n_vec = 0;
  int         n_bad = 0;
  int         tgt = 0;
  bit         chk_on = 1'b0;
  bit         exp_valid = 1'b0;
  bit         qpi_hold = 1'b0;
  bit         err_win = 1'b0;
  int         err_hits = 0;
  logic [3:0] exp_oe = 4'h0;
  logic [3:0] exp_do = 4'h0;
  bit         exp_qpi [2] = '{1'b0, 1'b0};
  int         wrap_of [2] = '{0, 4};
  logic [7:0] mem_m [2][DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst address advance from the wrap rule, in plain arithmetic.
  function automatic logic [AW-1:0] adv(input logic [AW-1:0] a, input int wrap);
    if (wrap == 0) return a + 1'b1;
    return AW'((int'(a) / wrap) * wrap + (int'(a) % wrap + 1) % wrap);
  endfunction

  // Per-cycle compare against the model expectations.
  always @(negedge clock) begin
    if (chk_on) begin
      if (!qpi_hold) begin
        check("qpi_mode_a", {63'd0, qpi_a}, {63'd0, exp_qpi[0]});
        check("qpi_mode_b", {63'd0, qpi_b}, {63'd0, exp_qpi[1]});
      end
      if (err_win) begin
        if (err_a) err_hits++;
      end else begin
        check("err_a", {63'd0, err_a}, 64'd0);
      end
      check("err_b", {63'd0, err_b}, 64'd0);
      if (exp_valid) begin
        check("dio_oe", {60'd0, tgt != 0 ? dio_oe_b : dio_oe_a}, {60'd0, exp_oe});
        check("unselected_oe", {60'd0, tgt != 0 ? dio_oe_a : dio_oe_b}, 64'd0);
        if (exp_oe != 4'h0)
          check("dio_o", {60'd0, tgt != 0 ? dio_o_b : dio_o_a}, {60'd0, exp_do});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Change sck and hold it 3 clocks; expectations apply after 1 clock.
  task automatic set_sck(input logic v, input logic [3:0] oe, input logic [3:0] d);
    exp_valid = 1'b0;
    sck       = v;
    exp_oe    = oe;
    exp_do    = d;
    step(1);
    exp_valid = 1'b1;
    step(2);
  endtask

  task automatic pulse(input logic [3:0] din, input logic [3:0] oe, input logic [3:0] d);
    dio_i = din;
    set_sck(1'b1, exp_oe, exp_do);
    set_sck(1'b0, oe, d);
  endtask

  task automatic set_ce(input logic v);
    if (tgt == 0) ce_n_a = v;
    else          ce_n_b = v;
  endtask

  task automatic ce_low();
    exp_valid = 1'b0;
    set_ce(1'b0);
    step(1);
    exp_valid = 1'b1;
    step(1);
  endtask

  task automatic ce_high(input bit q_after);
    exp_valid = 1'b0;
    qpi_hold  = 1'b1;
    set_ce(1'b1);
    exp_oe    = 4'h0;
    step(1);
    exp_qpi[tgt] = q_after;
    qpi_hold     = 1'b0;
    exp_valid    = 1'b1;
    step(2);
  endtask

  task automatic send_cmd(input logic [7:0] c, input int nbits);
    if (exp_qpi[tgt]) begin
      for (int i = 0; i < nbits / 4; i++) pulse(c[7-4*i -: 4], 4'h0, 4'h0);
    end else begin
      for (int i = 0; i < nbits; i++) pulse({3'($urandom), c[7-i]}, 4'h0, 4'h0);
    end
  endtask

  task automatic send_addr(input logic [23:0] a, input bit rd);
    for (int i = 0; i < 6; i++) pulse(a[23-4*i -: 4], (rd && i == 5) ? 4'hF : 4'h0, 4'h0);
  endtask

  task automatic set_mode(input bit on);
    ce_low();
    send_cmd(on ? 8'h35 : 8'hF5, 8);
    ce_high(on);
    $display("mode  t%0d qpi=%0d", tgt, on);
  endtask

  task automatic write_txn(input logic [23:0] a, input logic [3:0] nibs [$]);
    logic [AW-1:0] p;
    p = a[AW-1:0];
    ce_low();
    send_cmd(8'h38, 8);
    send_addr(a, 1'b0);
    foreach (nibs[i]) pulse(nibs[i], 4'h0, 4'h0);
    ce_high(exp_qpi[tgt]);
    for (int i = 0; i + 1 < nibs.size(); i += 2) begin
      mem_m[tgt][p] = {nibs[i], nibs[i+1]};
      p = adv(p, wrap_of[tgt]);
    end
    $display("write t%0d qpi=%0d a=%06h nibbles=%0d", tgt, exp_qpi[tgt], a, nibs.size());
  endtask

  task automatic write_hex(input logic [23:0] a, input logic [63:0] v, input int nn);
    logic [3:0] q [$];
    for (int i = 0; i < nn; i++) q.push_back(v[4*(nn-1-i) +: 4]);
    write_txn(a, q);
  endtask

  // Read nn nibbles; model supplies expected data, val returns what the DUT drove.
  task automatic read_txn(input logic [23:0] a, input int nn, output logic [63:0] val);
    logic [AW-1:0] p;
    logic [3:0]    en [$];
    p   = a[AW-1:0];
    val = 64'd0;
    for (int i = 0; i < nn; i++) begin
      en.push_back((i % 2 == 0) ? mem_m[tgt][p][7:4] : mem_m[tgt][p][3:0]);
      if (i % 2 == 1) p = adv(p, wrap_of[tgt]);
    end
    ce_low();
    send_cmd(8'hEB, 8);
    send_addr(a, 1'b1);
    for (int k = 1; k <= RW; k++) pulse(4'($urandom), 4'hF, (k == RW) ? en[0] : 4'h0);
    val = {val[59:0], (tgt != 0) ? dio_o_b : dio_o_a};
    for (int j = 1; j < nn; j++) begin
      pulse(4'($urandom), 4'hF, en[j]);
      val = {val[59:0], (tgt != 0) ? dio_o_b : dio_o_a};
    end
    ce_high(exp_qpi[tgt]);
    $display("read  t%0d qpi=%0d a=%06h nibbles=%0d data=%0h", tgt, exp_qpi[tgt], a, nn, val);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no finish after %0d ns", 5_000_000);
    $fatal(1);
  end

  initial begin
    logic [63:0] got;
    logic [3:0]  nq [$];
    logic [AW-1:0] p;
    int wl, off, rn;

    step(4);
    reset = 1'b0;
    step(1);
    check("rst_dio_o", {60'd0, dio_o_a}, 64'd0);
    check("rst_dio_oe", {60'd0, dio_oe_a}, 64'd0);
    check("rst_qpi", {63'd0, qpi_a}, 64'd0);
    check("rst_err", {63'd0, err_a}, 64'd0);
    chk_on    = 1'b1;
    exp_valid = 1'b1;

    // SPI write then SPI read of the same four bytes.
    tgt = 0;
    write_hex(24'h000010, 64'h12345678, 8);
    read_txn(24'h000010, 8, got);
    check("spi_read_10", got, 64'h12345678);

    // Enter QPI, read in QPI, leave QPI.
    set_mode(1'b1);
    read_txn(24'h000010, 4, got);
    check("qpi_read_10", got, 64'h1234);
    set_mode(1'b0);

    // Truncated enter-QPI command must not change the mode.
    ce_low();
    send_cmd(8'h35, 4);
    ce_high(exp_qpi[tgt]);

    // Wrapped burst on the wrap instance.
    tgt = 1;
    write_hex(24'h000000, 64'hAABBCCDD, 8);
    read_txn(24'h000002, 12, got);
    check("wrap_read", got, 64'hCCDDAABBCCDD);

    // Unsupported command: one err pulse, no write, outputs stay off.
    tgt = 0;
    err_hits = 0;
    ce_low();
    err_win = 1'b1;
    send_cmd(8'h9F, 8);
    for (int i = 0; i < 8; i++) pulse((i == 4) ? 4'h1 : 4'hF, 4'h0, 4'h0);
    err_win = 1'b0;
    ce_high(exp_qpi[tgt]);
    check("err_pulse_width", 64'(err_hits), 64'd1);
    read_txn(24'h000010, 4, got);
    check("after_err_read", got, 64'h1234);

    // Partial trailing byte is dropped.
    write_hex(24'h000020, 64'h005A, 4);
    write_hex(24'h000020, 64'hABC, 3);
    read_txn(24'h000020, 4, got);
    check("partial_write", got, 64'hAB5A);

    // Reset in the middle of a QPI write.
    set_mode(1'b1);
    ce_low();
    send_cmd(8'h38, 8);
    send_addr(24'h000010, 1'b0);
    pulse(4'hA, 4'h0, 4'h0);
    exp_valid = 1'b0;
    qpi_hold  = 1'b1;
    reset     = 1'b1;
    ce_n_a    = 1'b1;
    step(2);
    reset      = 1'b0;
    exp_qpi[0] = 1'b0;
    exp_oe     = 4'h0;
    step(1);
    qpi_hold  = 1'b0;
    exp_valid = 1'b1;
    step(2);
    $display("reset during write t0");
    check("reset_qpi", {63'd0, qpi_a}, 64'd0);
    read_txn(24'h000010, 4, got);
    check("after_reset_read", got, 64'h1234);

    // Randomized write/read pairs on both instances, both modes.
    for (int it = 0; it < 30; it++) begin
      tgt = $urandom_range(1, 0);
      if ($urandom_range(3, 0) == 0) set_mode(!exp_qpi[tgt]);
      wl = $urandom_range(6, 4);
      nq.delete();
      for (int i = 0; i < 2 * wl; i++) nq.push_back(4'($urandom));
      if ($urandom_range(1, 0) == 1) nq.push_back(4'($urandom));
      p = AW'($urandom);
      write_txn({12'($urandom), p}, nq);
      off = $urandom_range(wl - 1, 0);
      for (int i = 0; i < off; i++) p = adv(p, wrap_of[tgt]);
      rn = $urandom_range(2 * (wl - off), 1);
      read_txn({12'($urandom), p}, rn, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
